// File: rtl/mux_pkg.sv
// Shared types and helpers for the registered N_IN:1 channel mux.
package mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic MUX_MODE_DIRECT = 1'b0;
  localparam logic MUX_MODE_SCAN   = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/mux_next_ch.sv
// Priority finder: lowest set mask bit strictly above ptr, or lowest set bit when first.
module mux_next_ch
  import mux_pkg::*;
#(
  parameter int unsigned N_IN  = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic [N_IN-1:0]  mask,
  input  logic [SEL_W-1:0] ptr,
  input  logic             first,
  output logic [SEL_W-1:0] nxt,
  output logic             found
);

  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (!found && mask[i] && (first || i > 32'(ptr))) begin
        nxt   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_seq.sv
// Registered N_IN:1 channel mux with valid/ready output, direct-select and mask-scan modes.
module mux_seq
  import mux_pkg::*;
#(
  parameter int unsigned N_IN   = 16,
  parameter int unsigned SEL_W  = 4,
  parameter int unsigned DATA_W = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mode,
  input  logic                     req,
  input  logic [SEL_W-1:0]         ctrl,
  input  logic                     start,
  input  logic [N_IN-1:0]          en_mask,
  input  logic [N_IN*DATA_W-1:0]   in,
  output logic [DATA_W-1:0]        out,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned SEL_W_REQ = clog2(N_IN);

  if (SEL_W != SEL_W_REQ) begin : g_bad_sel_w
    $error("mux_seq: SEL_W must equal clog2(N_IN)");
  end

  state_t            state, state_nx;
  logic [N_IN-1:0]   mask_q;
  logic [SEL_W-1:0]  ptr_q, ptr_nx;
  logic              slot_free, load, cap, done_nx;
  logic [SEL_W-1:0]  fnd_ch;
  logic              fnd_ok;
  logic [SEL_W-1:0]  sel_idx, sel_ch;
  logic [DATA_W-1:0] sel_data;

  assign slot_free = !out_valid || out_ready;
  assign busy      = (state == SCAN);

  // One finder serves both the start lookup (live mask) and the in-scan advance (captured mask).
  mux_next_ch #(
    .N_IN  (N_IN),
    .SEL_W (SEL_W)
  ) u_next (
    .mask  ((state == IDLE) ? en_mask : mask_q),
    .ptr   (ptr_q),
    .first (state == IDLE),
    .nxt   (fnd_ch),
    .found (fnd_ok)
  );

  // Out-of-range index falls back to channel 0, as the legacy mux did.
  always_comb begin
    sel_idx  = (state == SCAN) ? ptr_q : ctrl;
    sel_data = in[DATA_W-1:0];
    sel_ch   = '0;
    for (int unsigned k = 0; k < N_IN; k++) begin
      if (32'(sel_idx) == k) begin
        sel_data = in[k*DATA_W +: DATA_W];
        sel_ch   = sel_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // A start seen while done is still high is dropped, so back-to-back scans need a fresh start.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    cap      = 1'b0;
    ptr_nx   = ptr_q;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (mode == MUX_MODE_DIRECT) begin
          load = req && slot_free;
        end else if (start && !done) begin
          cap = 1'b1;
          if (fnd_ok) begin
            ptr_nx   = fnd_ch;
            state_nx = SCAN;
          end else begin
            done_nx = 1'b1;
          end
        end
      end
      SCAN: begin
        if (slot_free) begin
          load = 1'b1;
          if (fnd_ok) begin
            ptr_nx = fnd_ch;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      ptr_q     <= '0;
      done      <= 1'b0;
      out       <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (cap) mask_q <= en_mask;
      ptr_q <= ptr_nx;
      done  <= done_nx;
      if (load) begin
        out       <= sel_data;
        out_ch    <= sel_ch;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_seq.sv
// Directed bench for mux_seq: direct mode, backpressure, scan, empty mask, out-of-range select, reset mid-scan.
module tb_mux_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         mode, req, start, out_ready;
  logic [3:0]   ctrl;
  logic [15:0]  en_mask;
  logic [127:0] in16;
  logic [7:0]   out;
  logic [3:0]   out_ch;
  logic         out_valid, busy, done;

  logic         req12;
  logic [3:0]   ctrl12;
  logic [7:0]   out12;
  logic [3:0]   out_ch12;
  logic         out_valid12, busy12, done12;

  int unsigned  n_chk = 0;
  int unsigned  n_err = 0;
  int unsigned  busy_cnt;

  always #5 clk = ~clk;

  mux_seq #(.N_IN(16), .SEL_W(4), .DATA_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .req(req), .ctrl(ctrl),
    .start(start), .en_mask(en_mask), .in(in16),
    .out(out), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  mux_seq #(.N_IN(12), .SEL_W(4), .DATA_W(8)) u_dut12 (
    .clk(clk), .rst_n(rst_n), .mode(1'b0), .req(req12), .ctrl(ctrl12),
    .start(1'b0), .en_mask(12'h000), .in(in16[95:0]),
    .out(out12), .out_ch(out_ch12), .out_valid(out_valid12), .out_ready(1'b1),
    .busy(busy12), .done(done12)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_beat(input string tag, input logic [3:0] ch);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".ch"},    32'(out_ch),    32'(ch));
    chk({tag, ".data"},  32'(out),       32'h10 + 32'(ch));
  endtask

  initial begin
    for (int k = 0; k < 16; k++) in16[k*8 +: 8] = 8'h10 + 8'(k);
    rst_n = 1'b0; mode = 1'b0; req = 1'b0; start = 1'b0; out_ready = 1'b1;
    ctrl = 4'd0; en_mask = '0; req12 = 1'b0; ctrl12 = 4'd11;
    #12;
    chk("rst.out",   32'(out),       32'h0);
    chk("rst.ch",    32'(out_ch),    32'h0);
    chk("rst.valid", 32'(out_valid), 32'h0);
    chk("rst.busy",  32'(busy),      32'h0);
    chk("rst.done",  32'(done),      32'h0);
    tick();
    rst_n = 1'b1;

    // direct mode, ctrl = 5, req held
    mode = 1'b0; req = 1'b1; ctrl = 4'd5; req12 = 1'b1;
    tick();
    chk_beat("dir0", 4'd5);
    chk("oor.in_range.data", 32'(out12),    32'h1B);
    chk("oor.in_range.ch",   32'(out_ch12), 32'd11);
    ctrl12 = 4'd13;
    tick();
    chk_beat("dir1", 4'd5);
    chk("oor.data",  32'(out12),       32'h10);
    chk("oor.ch",    32'(out_ch12),    32'd0);
    chk("oor.valid", 32'(out_valid12), 32'd1);
    req12 = 1'b0;

    // backpressure: held beat survives ctrl change
    out_ready = 1'b0; ctrl = 4'd9;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_beat("bp.hold", 4'd5);
    end
    out_ready = 1'b1;
    tick();
    chk_beat("bp.next", 4'd9);
    req = 1'b0;
    tick();
    chk("dir.drain", 32'(out_valid), 32'd0);

    // scan 0x8421, mask changed after capture
    mode = 1'b1; en_mask = 16'h8421; start = 1'b1; ctrl = 4'd3; req = 1'b1;
    busy_cnt = 0;
    tick();
    start = 1'b0; en_mask = 16'hFFFF;
    chk("scan.start.valid", 32'(out_valid), 32'd0);
    if (busy) busy_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_beat("scan.beat", 4'(5 * i));
      chk("scan.done", 32'(done), (i == 3) ? 32'd1 : 32'd0);
      if (busy) busy_cnt++;
    end
    tick();
    chk("scan.after.done",  32'(done),      32'd0);
    chk("scan.after.valid", 32'(out_valid), 32'd0);
    if (busy) busy_cnt++;
    chk("scan.busy_cycles", busy_cnt, 32'd4);
    req = 1'b0;

    // scan 0x0003 with ready toggling
    en_mask = 16'h0003; start = 1'b1;
    tick();
    start = 1'b0;
    chk("tog.busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    chk_beat("tog.b0", 4'd0);
    chk("tog.done0", 32'(done), 32'd0);
    out_ready = 1'b0;
    tick();
    chk_beat("tog.stall", 4'd0);
    out_ready = 1'b1;
    tick();
    chk_beat("tog.b1", 4'd1);
    chk("tog.done1", 32'(done), 32'd1);
    chk("tog.busy1", 32'(busy), 32'd0);
    out_ready = 1'b0;
    tick();
    chk_beat("tog.hold1", 4'd1);
    chk("tog.done2", 32'(done), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("tog.nodup", 32'(out_valid), 32'd0);

    // empty mask; start held into the done cycle is dropped
    en_mask = 16'h0000; start = 1'b1;
    tick();
    chk("empty.done",  32'(done),      32'd1);
    chk("empty.busy",  32'(busy),      32'd0);
    chk("empty.valid", 32'(out_valid), 32'd0);
    tick();
    start = 1'b0;
    chk("empty.done_once", 32'(done),      32'd0);
    chk("empty.valid2",    32'(out_valid), 32'd0);

    // reset mid-scan after two beats
    en_mask = 16'h00F0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk_beat("rs.b0", 4'd4);
    tick();
    chk_beat("rs.b1", 4'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rs.out",   32'(out),       32'h0);
    chk("rs.ch",    32'(out_ch),    32'h0);
    chk("rs.valid", 32'(out_valid), 32'h0);
    chk("rs.busy",  32'(busy),      32'h0);
    chk("rs.done",  32'(done),      32'h0);
    #1 rst_n = 1'b1;
    tick();
    chk("rs.idle.busy",  32'(busy),      32'd0);
    chk("rs.idle.valid", 32'(out_valid), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rs.restart.busy", 32'(busy), 32'd1);
    tick();
    chk_beat("rs.restart", 4'd4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_seq.md
Name: mux_seq

Overview:
- Parametrised, registered successor of the fixed 16:1 single-bit mux.
- Selects one of N_IN channels of DATA_W bits and presents it on a valid/ready output register.
- Two modes:
  - Direct: per-request select from ctrl.
  - Scan: autonomous sweep over a channel-enable mask, one beat per enabled channel.
- Sits between sampled input banks and a downstream consumer that may stall.

Parameters:
- N_IN, 16, number of input channels (2..256).
- SEL_W, 4, select width; must equal ceil(log2(N_IN)).
- DATA_W, 1, bits per channel.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- mode  in  1  0 = direct, 1 = scan; sampled only in IDLE.
- req  in  1  direct-mode request (level); a beat is taken when the output slot is free.
- ctrl  in  SEL_W  direct-mode channel select.
- start  in  1  scan-mode start pulse.
- en_mask  in  N_IN  scan channel-enable mask, captured at start.
- in  in  N_IN*DATA_W  channel data; channel k is in[k*DATA_W +: DATA_W].
- out  out  DATA_W  registered selected data.
- out_ch  out  SEL_W  channel index of the current out beat.
- out_valid  out  1  out/out_ch hold a beat.
- out_ready  in  1  consumer accepts the beat when out_valid & out_ready.
- busy  out  1  high while in SCAN.
- done  out  1  one-cycle pulse when a scan completes.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled upstream):
  - out = 0, out_ch = 0, out_valid = 0, busy = 0, done = 0.
  - FSM state = IDLE, scan pointer = 0, captured mask = 0.
- Slot free: slot_free = !out_valid | out_ready. Loading into a free slot while the current beat is accepted is allowed, giving full throughput of one beat per cycle.
- Out-of-range select (index >= N_IN): returns channel 0 data with out_ch = 0. This is the same default as the legacy mux.
- FSM states: IDLE, SCAN.
- IDLE, mode = 0:
  - If req & slot_free, then next cycle out = in[ctrl], out_ch = ctrl, out_valid = 1.
  - Latency is 1 cycle from the request edge.
  - Data is sampled on the load edge, not later.
- IDLE, mode = 1, start = 1:
  - Capture en_mask.
  - If the mask is 0: done = 1 next cycle, stay IDLE, no beats.
  - Otherwise: pointer = lowest set bit, busy = 1, go to SCAN.
  - req is ignored in mode 1; start is ignored in mode 0.
- SCAN:
  - On each cycle with slot_free, load in[pointer] / pointer as a beat.
  - Then advance the pointer to the next higher set bit of the captured mask.
  - If there is no higher set bit, the load is the last beat: go to IDLE, busy = 0, done = 1 in the same edge that loads the last beat.
  - start, req, mode and ctrl are ignored while in SCAN.
  - Changes to en_mask mid-scan have no effect.
- Stall: while out_valid & !out_ready, out, out_ch and out_valid hold and the pointer does not advance.
- The last beat may still be pending in the output register after done; done refers to beat issue, not acceptance.
- Reset mid-scan: everything returns to its reset values immediately and the pending beat is discarded.
- start arriving in the same cycle as done: ignored. A new scan needs start while in IDLE.

Decomposition:
- Shared package mux_pkg holds:
  - state enum (IDLE, SCAN);
  - helper function clog2;
  - MUX_MODE_DIRECT / MUX_MODE_SCAN constants.
- One sub-module, mux_next_ch: combinational priority finder.
  - Inputs: mask, current pointer, first flag.
  - Outputs: next set index above the pointer (or the lowest set bit when first), plus a found flag.
- The top level holds the FSM, the output register and the N_IN:1 data selector.

Test Plan:
- Direct mode, N_IN = 16, DATA_W = 8, in[k] = 8'h10+k, ctrl = 5, req held 1, out_ready = 1 -> from the cycle after req, out = 8'h15, out_ch = 5, out_valid = 1 every cycle.
- Direct backpressure: out_ready = 0 for 3 cycles while ctrl changes 5->9 -> out holds 8'h15 for those cycles; after out_ready rises, the next beat is 8'h19.
- Scan: en_mask = 16'h8421, out_ready = 1 -> beats on channels 0, 5, 10, 15 in consecutive cycles; done pulses with the channel-15 load; busy is high exactly 4 cycles.
- Scan with out_ready toggling 1,0,1,0 and en_mask = 16'h0003 -> exactly two beats (ch 0, ch 1) and no duplicates; done after the second load.
- en_mask = 0 with start -> done pulses once and out_valid stays 0. Out-of-range direct select, N_IN = 12 with ctrl = 13 -> out = in[0], out_ch = 0.
- Assert rst_n low mid-scan after 2 beats -> all outputs are 0 immediately; after release, state is IDLE and a new start scans from the lowest set bit.
